// File: rtl/sevenseg_pkg.sv
// Shared digit type, segment codes and elaboration helpers for the seven-segment scan controller.
package sevenseg_pkg;

  typedef logic [3:0] digit_t;

  // Active-high segment patterns, bit 6 = g down to bit 0 = a
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;

  function automatic logic [6:0] seg_encode(input digit_t d);
    logic [6:0] s;
    case (d)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      4'hF:    s = 7'h71;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] p;
    p = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift-add-3 step per cycle for W cycles.
// done_o and bcd_o present the final step's result combinationally so the caller can capture it on the edge busy falls.
module bin2bcd_seq #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_i,
  input  logic [W-1:0] bin_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] bcd_o
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  bin_q, bin_d;
  logic [W-1:0]  bcd_q, bcd_d;
  logic [W-1:0]  adj_s;
  logic [W-1:0]  step_bcd_s;

  function automatic logic [W-1:0] add3(input logic [W-1:0] b);
    logic [W-1:0] r;
    r = b;
    for (int i = 0; i < W / 4; i++) begin
      r[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? (b[4*i +: 4] + 4'd3) : b[4*i +: 4];
    end
    return r;
  endfunction

  // One conversion step and the handshake outputs
  always_comb begin
    adj_s      = add3(bcd_q);
    step_bcd_s = {adj_s[W-2:0], bin_q[W-1]};
    done_o     = busy_q && (cnt_q == LAST);
    bcd_o      = step_bcd_s;
    busy_o     = busy_q;
  end

  // Next-state: start, step, or hold
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    if (start_i && !busy_q) begin
      busy_d = 1'b1;
      cnt_d  = {CW{1'b0}};
      bin_d  = bin_i;
      bcd_d  = {W{1'b0}};
    end else if (busy_q) begin
      bin_d  = {bin_q[W-2:0], 1'b0};
      bcd_d  = step_bcd_s;
      cnt_d  = cnt_q + CW'(1);
      busy_d = (cnt_q != LAST);
    end else begin
      busy_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= {CW{1'b0}};
      bin_q  <= {W{1'b0}};
      bcd_q  <= {W{1'b0}};
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
    end
  end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// N-digit multiplexed seven-segment driver with hex/decimal display, leading-zero blanking and live dp.
// Defining SEVENSEG_BRIGHTNESS_EN adds a 4-bit brightness input that gates the duty cycle of each digit slot.
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 131072,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic                    mode,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   dp_in,
`ifdef SEVENSEG_BRIGHTNESS_EN
  input  logic [3:0]              brightness,
`endif
  output logic                    busy,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              seg
);

  localparam int VW = 4 * NUM_DIGITS;
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] PS_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [63:0]   DEC_LIMIT = pow10(NUM_DIGITS) - 64'd1;
  localparam logic [NUM_DIGITS-1:0] AN_OFF =
    (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic [7:0] SEG_OFF = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [VW-1:0]         disp_q, disp_d;
  logic                  dash_q, dash_d;
  logic                  blank_q, blank_d;
  logic                  mode_q, mode_d;
  logic                  ovf_q, ovf_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [7:0]            seg_q, seg_d;

  logic                  conv_busy_s;
  logic                  conv_done_s;
  logic [VW-1:0]         conv_bcd_s;
  logic                  accept_s;
  logic                  conv_start_s;
  logic                  on_s;
  logic                  zero_run_s;
  logic                  lz_s;
  logic                  cur_dp_s;
  digit_t                cur_digit_s;
  logic [6:0]            seg7_s;
  logic [NUM_DIGITS-1:0] an_hi_s;
  logic [7:0]            seg_hi_s;

  assign accept_s     = load && !conv_busy_s;
  assign conv_start_s = accept_s && mode;
  assign busy         = conv_busy_s;
  assign an           = an_q;
  assign seg          = seg_q;

  bin2bcd_seq #(
    .W (VW)
  ) u_bin2bcd (
    .clk     (clk),
    .reset   (reset),
    .start_i (conv_start_s),
    .bin_i   (value),
    .busy_o  (conv_busy_s),
    .done_o  (conv_done_s),
    .bcd_o   (conv_bcd_s)
  );

  // Refresh prescaler and digit index
  always_comb begin
    presc_d = presc_q;
    idx_d   = idx_q;
    if (presc_q == PS_LAST) begin
      presc_d = {PW{1'b0}};
      idx_d   = (idx_q == IDX_LAST) ? {IW{1'b0}} : (idx_q + IW'(1));
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  // Load capture and conversion result; a load during conversion is dropped
  always_comb begin
    disp_d  = disp_q;
    dash_d  = dash_q;
    blank_d = blank_q;
    mode_d  = mode_q;
    ovf_d   = ovf_q;
    if (accept_s) begin
      mode_d  = mode;
      blank_d = blank_lz;
      if (!mode) begin
        disp_d = value;
        dash_d = 1'b0;
      end else begin
        ovf_d = ({{(64-VW){1'b0}}, value} > DEC_LIMIT);
      end
    end else if (conv_done_s && mode_q) begin
      disp_d = conv_bcd_s;
      dash_d = ovf_q;
    end else begin
      disp_d = disp_q;
    end
  end

  // Current digit, its dp, and whether it lies in the leading-zero run
  always_comb begin
    zero_run_s  = 1'b1;
    lz_s        = 1'b0;
    cur_dp_s    = 1'b0;
    cur_digit_s = 4'h0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run_s  = zero_run_s && (disp_q[4*i +: 4] == 4'h0);
      cur_digit_s = (idx_q == IW'(i)) ? disp_q[4*i +: 4] : cur_digit_s;
      cur_dp_s    = (idx_q == IW'(i)) ? dp_in[i] : cur_dp_s;
      lz_s        = (idx_q == IW'(i)) ? (zero_run_s && (i != 0)) : lz_s;
    end
  end

`ifdef SEVENSEG_BRIGHTNESS_EN
  logic [3:0]  bright_q, bright_d;
  logic [3:0]  duty_s;
  logic [63:0] thr_s;

  // Duty level is taken from the live input in a slot's first cycle and held for the rest
  always_comb begin
    duty_s   = (presc_q == {PW{1'b0}}) ? brightness : bright_q;
    bright_d = duty_s;
    thr_s    = ((64'(duty_s) + 64'd1) * 64'(REFRESH_DIV)) / 64'd16;
    on_s     = (64'(presc_q) < thr_s);
  end

  // Brightness hold register
  always_ff @(posedge clk) begin
    if (reset) begin
      bright_q <= 4'hF;
    end else begin
      bright_q <= bright_d;
    end
  end
`else
  assign on_s = 1'b1;
`endif

  // Segment/anode pattern for the current slot, then output polarity
  always_comb begin
    if (dash_q) begin
      seg7_s = SEG_DASH;
    end else if (blank_q && lz_s) begin
      seg7_s = SEG_BLANK;
    end else begin
      seg7_s = seg_encode(cur_digit_s);
    end
    if (on_s) begin
      an_hi_s  = NUM_DIGITS'(1) << idx_q;
      seg_hi_s = {cur_dp_s, seg7_s};
    end else begin
      an_hi_s  = {NUM_DIGITS{1'b0}};
      seg_hi_s = 8'h00;
    end
    if (ACTIVE_LOW != 0) begin
      an_d  = ~an_hi_s;
      seg_d = ~seg_hi_s;
    end else begin
      an_d  = an_hi_s;
      seg_d = seg_hi_s;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= {PW{1'b0}};
      idx_q   <= {IW{1'b0}};
      disp_q  <= {VW{1'b0}};
      dash_q  <= 1'b0;
      blank_q <= 1'b0;
      mode_q  <= 1'b0;
      ovf_q   <= 1'b0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      disp_q  <= disp_d;
      dash_q  <= dash_d;
      blank_q <= blank_d;
      mode_q  <= mode_d;
      ovf_q   <= ovf_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed bench for sevenseg_scan_ctrl (4 digits, 4-cycle slots, active-low) with a cycle-by-cycle reference model.
module tb_sevenseg_scan_ctrl;

  localparam int N   = 4;
  localparam int DIV = 4;
  localparam int LIM = 9999;

  logic         clk;
  logic         reset;
  logic [15:0]  value;
  logic         load;
  logic         mode;
  logic         blank_lz;
  logic [3:0]   dp_in;
  logic         busy;
  logic [3:0]   an;
  logic [7:0]   seg;

  int errors = 0;
  int checks = 0;

  // reference model state
  int         t_rel;
  int         md_dig [N];
  bit         md_dash;
  bit         md_blank;
  int         conv_left;
  int         conv_val;
  logic [3:0] exp_an;
  logic [7:0] exp_seg;
  logic       exp_busy;

  sevenseg_scan_ctrl #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (DIV),
    .ACTIVE_LOW  (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .value      (value),
    .load       (load),
    .mode       (mode),
    .blank_lz   (blank_lz),
    .dp_in      (dp_in),
`ifdef SEVENSEG_BRIGHTNESS_EN
    .brightness (4'hF),
`endif
    .busy       (busy),
    .an         (an),
    .seg        (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic logic [6:0] hex_lo(input int d);
    case (d)
      0:  return 7'b1000000;
      1:  return 7'b1111001;
      2:  return 7'b0100100;
      3:  return 7'b0110000;
      4:  return 7'b0011001;
      5:  return 7'b0010010;
      6:  return 7'b0000010;
      7:  return 7'b1111000;
      8:  return 7'b0000000;
      9:  return 7'b0010000;
      10: return 7'b0001000;
      11: return 7'b0000011;
      12: return 7'b1000110;
      13: return 7'b0100001;
      14: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs sampled at that edge
  task automatic model_step();
    int         idx;
    int         v;
    bit         zr;
    logic [6:0] s7;
    if (reset) begin
      exp_an    = 4'hF;
      exp_seg   = 8'hFF;
      exp_busy  = 1'b0;
      t_rel     = 0;
      md_dash   = 1'b0;
      md_blank  = 1'b0;
      conv_left = 0;
      for (int i = 0; i < N; i++) md_dig[i] = 0;
    end else begin
      idx = (t_rel / DIV) % N;
      zr  = 1'b1;
      for (int i = idx; i < N; i++) if (md_dig[i] != 0) zr = 1'b0;
      if (md_dash) s7 = 7'b0111111;
      else if (md_blank && idx > 0 && zr) s7 = 7'b1111111;
      else s7 = hex_lo(md_dig[idx]);
      exp_an  = ~(4'b0001 << idx);
      exp_seg = {~dp_in[idx], s7};
      t_rel++;
      if (conv_left > 0) begin
        conv_left--;
        if (conv_left == 0) begin
          if (conv_val > LIM) begin
            md_dash = 1'b1;
          end else begin
            md_dash = 1'b0;
            v = conv_val;
            for (int i = 0; i < N; i++) begin
              md_dig[i] = v % 10;
              v = v / 10;
            end
          end
        end
      end else if (load) begin
        md_blank = blank_lz;
        if (!mode) begin
          md_dash = 1'b0;
          for (int i = 0; i < N; i++) md_dig[i] = int'(value[4*i +: 4]);
        end else begin
          conv_val  = int'(value);
          conv_left = 4 * N;
        end
      end
      exp_busy = (conv_left > 0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("model_an",   32'(an),   32'(exp_an));
    check("model_seg",  32'(seg),  32'(exp_seg));
    check("model_busy", 32'(busy), 32'(exp_busy));
  endtask

  // Wait (bounded) for a given anode, then pin the full seg byte to a literal
  task automatic expect_digit(input string name, input logic [3:0] pat, input logic [7:0] lit);
    int n;
    n = 0;
    tick();
    while (an !== pat && n < 3 * N * DIV) begin
      tick();
      n++;
    end
    check({name, "_an"}, 32'(an), 32'(pat));
    check(name, 32'(seg), 32'(lit));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
    check("idle", 32'(busy), 32'd0);
  endtask

  logic [3:0] scan_pat [4];
  int         nb;

  initial begin
    scan_pat = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    reset = 1'b1; value = 16'h0000; load = 1'b0; mode = 1'b0;
    blank_lz = 1'b0; dp_in = 4'b0000;
    tick();
    tick();
    check("rst_an",   32'(an),   32'h0000000F);
    check("rst_seg",  32'(seg),  32'h000000FF);
    check("rst_busy", 32'(busy), 32'd0);

    reset = 1'b0;
    for (int j = 0; j < 16; j++) begin
      tick();
      check("scan_an",  32'(an),       32'(scan_pat[j / 4]));
      check("scan_seg", 32'(seg[6:0]), 32'(7'b1000000));
    end

    value = 16'h1A0F; mode = 1'b0; load = 1'b1;
    tick();
    load = 1'b0;
    expect_digit("hex_d0", 4'b1110, {1'b1, 7'b0001110});
    expect_digit("hex_d1", 4'b1101, {1'b1, 7'b1000000});
    expect_digit("hex_d2", 4'b1011, {1'b1, 7'b0001000});
    expect_digit("hex_d3", 4'b0111, {1'b1, 7'b1111001});

    value = 16'd1234; mode = 1'b1; load = 1'b1;
    tick();
    load = 1'b0;
    nb = 0;
    while (busy === 1'b1 && nb < 40) begin
      nb++;
      if (nb == 5) begin
        value = 16'h9999; mode = 1'b0; load = 1'b1;
      end
      tick();
      load = 1'b0;
    end
    check("busy_len", 32'(nb), 32'd16);
    expect_digit("dec_d3", 4'b0111, {1'b1, 7'b1111001});
    expect_digit("dec_d2", 4'b1011, {1'b1, 7'b0100100});
    expect_digit("dec_d1", 4'b1101, {1'b1, 7'b0110000});
    expect_digit("dec_d0", 4'b1110, {1'b1, 7'b0011001});

    value = 16'd10000; mode = 1'b1; load = 1'b1;
    tick();
    load = 1'b0;
    wait_idle();
    for (int j = 0; j < 4; j++) expect_digit("dash", scan_pat[j], {1'b1, 7'b0111111});

    value = 16'h0007; mode = 1'b0; blank_lz = 1'b1; dp_in = 4'b0100; load = 1'b1;
    tick();
    load = 1'b0;
    expect_digit("lz_d3", 4'b0111, {1'b1, 7'b1111111});
    expect_digit("lz_d2", 4'b1011, {1'b0, 7'b1111111});
    expect_digit("lz_d1", 4'b1101, {1'b1, 7'b1111111});
    expect_digit("lz_d0", 4'b1110, {1'b1, 7'b1111000});

    dp_in = 4'b0000; blank_lz = 1'b0;
    value = 16'd4321; mode = 1'b1; load = 1'b1;
    tick();
    load = 1'b0;
    for (int j = 0; j < 4; j++) tick();
    reset = 1'b1;
    tick();
    check("abort_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    for (int j = 0; j < 4; j++) expect_digit("abort_zero", scan_pat[j], {1'b1, 7'b1000000});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
